// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer handshakes plus FIFO write-side signals shared
// by the round-robin write arbiter. The master modport is the arbiter side;
// the slave modport is the producers/FIFO environment side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNTW   = $clog2(DEPTH) + 1
);
  localparam int unsigned GW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_wr_en;
  logic [DWIDTH-1:0]      fifo_din;
  logic                   fifo_full;
  logic [CNTW-1:0]        fifo_count;
  logic [GW-1:0]          grant_id;
  logic                   busy;

  modport master (
    input  req_valid,
    input  req_data,
    input  fifo_full,
    input  fifo_count,
    output req_ready,
    output fifo_wr_en,
    output fifo_din,
    output grant_id,
    output busy
  );

  modport slave (
    output req_valid,
    output req_data,
    output fifo_full,
    output fifo_count,
    input  req_ready,
    input  fifo_wr_en,
    input  fifo_din,
    input  grant_id,
    input  busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// NREQ valid/ready producers. Each grant lasts up to BURST words, stalls while
// the FIFO is full, and costs one IDLE cycle before the next grant.
// Optional per-requester accepted-word counters: define FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned BURST  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNTW   = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  fifo_wr_arbiter_if.master bus
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_xfer_cnt
`endif
);

  localparam int unsigned GW  = $clog2(NREQ);
  localparam int unsigned BCW = $clog2(BURST) + 1;
  localparam logic [BCW-1:0]  BURST_LAST = BCW'(BURST - 1);
  localparam logic [GW-1:0]   LAST_REQ   = GW'(NREQ - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT  = CNTW'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant_q, grant_nxt;
  logic [GW-1:0]   rr_ptr, rr_nxt;
  logic [GW-1:0]   grant_inc;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  logic            pick_vld;
  logic [BCW-1:0]  burst_cnt, burst_nxt;
  logic            blocked;
  logic            xfer;
  logic [NREQ-1:0] ready_c;

  // FIFO cannot take a word this cycle
  assign blocked = bus.fifo_full | (bus.fifo_count >= DEPTH_CNT);

  // Rotation target once the current grant ends, wrapping NREQ-1 -> 0
  assign grant_inc = (grant_q == LAST_REQ) ? '0 : grant_q + GW'(1);

  // First valid requester searching rr_ptr, rr_ptr+1, ... modulo NREQ
  always_comb begin
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = GW'((32'(rr_ptr) + i) % NREQ);
      if (!pick_vld && bus.req_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and handshake decode; reset masks every write-side strobe
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    rr_nxt    = rr_ptr;
    burst_nxt = burst_cnt;
    ready_c   = '0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick;
          burst_nxt = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        ready_c[grant_q] = ~blocked;
        xfer             = bus.req_valid[grant_q] & ~blocked;
        if (xfer) begin
          burst_nxt = burst_cnt + BCW'(1);
        end
        // A dropped valid or the last word of the burst hands over priority
        if ((xfer && (burst_cnt == BURST_LAST)) || !bus.req_valid[grant_q]) begin
          state_nxt = IDLE;
          rr_nxt    = grant_inc;
          burst_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      ready_c = '0;
      xfer    = 1'b0;
    end
  end

  // State, grant and rotation registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_din   = bus.req_data[32'(grant_q) * DWIDTH +: DWIDTH];
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state == GRANT);

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] xfer_cnt [NREQ];

  // Saturating accepted-word count for the granted requester
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        xfer_cnt[i] <= '0;
      end
    end else if (xfer && (xfer_cnt[grant_q] != 16'hFFFF)) begin
      xfer_cnt[grant_q] <= xfer_cnt[grant_q] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
    assign stat_xfer_cnt[gi*16 +: 16] = xfer_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: producer models with per-requester word streams, a
// scoreboard of expected {grant, data, cycle} writes, and a per-cycle vector
// table for the FIFO-full / occupancy stall sequence.
module tb_fifo_wr_arbiter;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned DWIDTH = 8;
  localparam int unsigned BURST  = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNTW   = 4;
  localparam int unsigned NVEC   = 13;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    int         cyc;
  } sb_t;

  typedef struct {
    logic       full;
    logic [3:0] count;
    logic       wr;
    logic [3:0] ready;
    logic       busy;
    logic [1:0] grant;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int         sent [NREQ];
  int         target [NREQ];
  int         exp_next [NREQ];
  logic [3:0] en;
  sb_t        sb [$];
  vec_t       vecs [NVEC];

  logic       s_wr;
  logic       s_busy;
  logic [3:0] s_ready;
  logic [1:0] s_grant;
  logic [7:0] s_din;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [NREQ*16-1:0] stat;
`endif

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DWIDTH(DWIDTH), .BURST(BURST), .DEPTH(DEPTH), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .stat_xfer_cnt(stat)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Producer i presents word n as i*32+n while it has words left and is enabled
  task automatic drive();
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_valid[i] = en[i] && (sent[i] < target[i]);
      bus.req_data[i*8 +: 8] = 8'(i*32 + sent[i]);
    end
  endtask

  task automatic push_word(input int id, input int c);
    sb_t e;
    e.id   = 2'(id);
    e.data = 8'(id*32 + exp_next[id]);
    e.cyc  = c;
    exp_next[id]++;
    sb.push_back(e);
  endtask

  // One clock: drive after the edge, sample at the falling edge, score writes
  task automatic tick();
    sb_t e;
    drive();
    @(negedge clk);
    s_wr    = bus.fifo_wr_en;
    s_busy  = bus.busy;
    s_ready = bus.req_ready;
    s_grant = bus.grant_id;
    s_din   = bus.fifo_din;
    if (s_wr) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: cycle %0d id %0d data 0x%02h, expected no write",
                 cyc, s_grant, s_din);
      end else begin
        e = sb.pop_front();
        if (s_grant !== e.id || s_din !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write_order: got id %0d data 0x%02h cycle %0d, expected id %0d data 0x%02h cycle %0d",
                   s_grant, s_din, cyc, e.id, e.data, e.cyc);
        end
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (s_ready[i] && bus.req_valid[i]) sent[i]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int b = budget;
    while (sb.size() > 0 && b > 0) begin
      tick();
      b--;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int b;

    // Stall sequence: requester 1 alone, FIFO full for 3 cycles, then an
    // occupancy-limited re-grant, then valid drop with ready still asserted
    vecs[0]  = '{1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 4'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{1'b0, 4'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[3]  = '{1'b1, 4'd0, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[4]  = '{1'b1, 4'd0, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[5]  = '{1'b1, 4'd0, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 4'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[7]  = '{1'b0, 4'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'd1};
    vecs[9]  = '{1'b0, 4'd8, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 4'd7, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[11] = '{1'b0, 4'd0, 1'b0, 4'b0010, 1'b1, 2'd1};
    vecs[12] = '{1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'd1};

    for (int i = 0; i < int'(NREQ); i++) begin
      sent[i] = 0;
      target[i] = 0;
      exp_next[i] = 0;
    end
    en = 4'b0000;
    rst = 1'b1;
    bus.fifo_full = 1'b0;
    bus.fifo_count = '0;
    drive();
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    tick();
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_grant", 32'(s_grant), 32'd0);
    check("rst_wr_en", 32'(s_wr), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);

    // Single requester, 6 words: 4-word burst, one IDLE cycle, 2 more words
    k = cyc;
    target[0] += 6;
    en = 4'b0001;
    for (int n = 0; n < 6; n++) push_word(0, k + 1 + n + n/4);
    drain(20);
    settle(3);

    // All valid from reset: grants 0,1,2,3,0 with 4 words each
    do_reset();
    k = cyc;
    target[0] += 8;
    target[1] += 4;
    target[2] += 4;
    target[3] += 4;
    en = 4'b1111;
    for (int n = 0; n < 20; n++) push_word((n/4) % 4, k + 1 + n + n/4);
    drain(40);
    settle(3);

    // FIFO full / occupancy stalls on requester 1
    k = cyc;
    target[1] += 5;
    en = 4'b0010;
    push_word(1, k + 1);
    push_word(1, k + 2);
    push_word(1, k + 6);
    push_word(1, k + 7);
    push_word(1, k + 10);
    for (int r = 0; r < int'(NVEC); r++) begin
      bus.fifo_full = vecs[r].full;
      bus.fifo_count = vecs[r].count;
      tick();
      check($sformatf("vec%0d_wr_en", r), 32'(s_wr), 32'(vecs[r].wr));
      check($sformatf("vec%0d_ready", r), 32'(s_ready), 32'(vecs[r].ready));
      check($sformatf("vec%0d_busy", r), 32'(s_busy), 32'(vecs[r].busy));
      check($sformatf("vec%0d_grant", r), 32'(s_grant), 32'(vecs[r].grant));
    end
    bus.fifo_full = 1'b0;
    bus.fifo_count = '0;
    drain(5);
    settle(2);

    // Requester 2 drops valid after one word; requester 3 is next
    k = cyc;
    target[2] += 1;
    target[3] += 4;
    en = 4'b1100;
    push_word(2, k + 1);
    for (int n = 0; n < 4; n++) push_word(3, k + 4 + n);
    tick();
    tick();
    tick();
    check("drop_hold_busy", 32'(s_busy), 32'd1);
    check("drop_hold_wr_en", 32'(s_wr), 32'd0);
    tick();
    check("drop_idle_busy", 32'(s_busy), 32'd0);
    drain(10);
    settle(2);

    // Reset during requester 3's second word
    k = cyc;
    target[3] += 4;
    en = 4'b1000;
    push_word(3, k + 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_wr_en", 32'(s_wr), 32'd0);
    check("midrst_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    b = cyc;
    en = 4'b1111;
    target[0] += 4;
    target[1] += 4;
    target[2] += 4;
    for (int n = 0; n < 12; n++) push_word(n/4, b + 1 + n + n/4);
    for (int n = 12; n < 15; n++) push_word(3, b + 1 + n + n/4);
    tick();
    check("postrst_busy", 32'(s_busy), 32'd0);
    check("postrst_grant", 32'(s_grant), 32'd0);
    drain(30);
    settle(3);

`ifdef FIFO_WR_ARBITER_STATS_EN
    // Two full rotations after reset: 8 accepted words per requester
    do_reset();
    k = cyc;
    for (int i = 0; i < int'(NREQ); i++) target[i] += 8;
    en = 4'b1111;
    for (int n = 0; n < 32; n++) push_word((n/4) % 4, k + 1 + n + n/4);
    drain(60);
    settle(3);
    for (int i = 0; i < int'(NREQ); i++) begin
      check($sformatf("stat_cnt%0d", i), 32'(stat[i*16 +: 16]), 32'd8);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO write port (wr_en/din/full/count) between NREQ independent producers.
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer at a time for a bounded burst, respects FIFO full, and rotates priority after each burst.
- Sits directly in front of the FIFO's write side; the read side is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DWIDTH, 8, data width, equal to the FIFO din width
- BURST, 4, maximum words per grant (1..16)
- DEPTH, 8, FIFO depth, used to interpret fifo_count
- CNTW, $clog2(DEPTH)+1, width of fifo_count

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  producer i has a word on req_data slice i
- req_data  in  NREQ*DWIDTH  producer i data at [i*DWIDTH +: DWIDTH]
- req_ready  out  NREQ  word from producer i is accepted this cycle
- fifo_wr_en  out  1  FIFO write enable
- fifo_din  out  DWIDTH  FIFO write data
- fifo_full  in  1  FIFO full flag
- fifo_count  in  CNTW  FIFO occupancy
- grant_id  out  $clog2(NREQ)  currently or last granted requester
- busy  out  1  high while in GRANT

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0, busy=0.
- req_ready and fifo_wr_en are forced 0 in any cycle where rst is high, including mid-burst. Reset aborts the burst and no write occurs in that cycle.
- blocked = fifo_full OR (fifo_count >= DEPTH).
- FSM states are IDLE and GRANT.
- IDLE:
  - req_ready=0, fifo_wr_en=0.
  - If any req_valid bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - Register that index into grant_id, clear burst_cnt, go to GRANT.
  - Latency: the first possible write is the cycle after the request is seen in IDLE.
- GRANT, with g=grant_id:
  - req_ready[g] = !blocked. All other req_ready bits are 0.
  - xfer = req_valid[g] & req_ready[g].
  - fifo_wr_en = xfer. fifo_din = req_data slice g. Both are combinational, so there are no pipeline bubbles within a burst.
  - On xfer, burst_cnt increments.
  - Exit to IDLE at the next edge if (xfer and burst_cnt==BURST-1) or req_valid[g]==0. On exit, rr_ptr = (g+1) mod NREQ and burst_cnt=0.
  - While blocked with req_valid[g] high: hold the grant, no write, burst_cnt unchanged, no timeout.
- Each burst costs exactly one IDLE cycle, so sustained throughput is BURST/(BURST+1) words per cycle.
- When not writing, fifo_din is driven with slice grant_id; the value does not matter.
- Producers must hold req_valid and data stable until ready. A drop of req_valid ends the burst; the arbiter does not check producer misbehaviour.
- A requester whose valid rises while another holds the grant waits for the rotation.
- Worst-case wait is (NREQ-1)*(BURST+1) cycles plus FIFO-full stall time.
- Wrap-around: rr_ptr wraps from NREQ-1 to 0. When only one requester is active it is re-granted after each IDLE cycle.

Optional Feature:
- Macro: FIFO_WR_ARBITER_STATS_EN.
- When defined:
  - Adds output stat_xfer_cnt, NREQ*16 bits, with a per-requester count of accepted words at slice [i*16 +: 16].
  - Counters increment on xfer for requester g, saturate at 16'hFFFF, and reset to 0 on rst.
- When undefined: the port and counters do not exist, and all other behaviour is identical.

Test Plan:
- Only req_valid[0] high with 6 words, BURST=4, FIFO empty -> fifo_wr_en high for 4 consecutive cycles, 1 IDLE cycle, then 2 more writes. grant_id=0 throughout; data written in order.
- All 4 req_valid held high -> grants in order 0,1,2,3,0. Each grant writes exactly 4 words with one IDLE cycle between grants.
- Requester 1 granted, fifo_full forced high after its 2nd word for 3 cycles -> req_ready[1]=0 and fifo_wr_en=0 for those 3 cycles. The burst then resumes with the remaining 2 words (4 total); busy stays 1.
- Requester 2 drops req_valid after 1 word while requester 3 is valid -> next edge goes to IDLE, then grant_id=3. Requester 2 writes 1 word only.
- rst pulsed for 1 cycle during requester 3's 2nd word -> no write in the reset cycle; busy=0 and grant_id=0 next cycle. With all valid, the next grant goes to requester 0.
- With FIFO_WR_ARBITER_STATS_EN, run the all-valid scenario for 2 full rotations -> each stat_xfer_cnt slice = 8.
